// File: rtl/data_access_unit.sv
// data_access_unit: memory-stage sequencer between the instruction controller and the
// data-memory port. It accepts a load (RREQ) or store (CWE) request, runs one req/ack
// transaction on the memory port and pulses RDY when the access completes. Stores get
// byte-lane steering. Loads get lane alignment plus sign or zero extension.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   RREQ, CWE         load / store request levels from the controller (CWE wins)
//   FUNCT3            access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ADDR, WDATA       effective byte address and store data (rs2)
//   RDY, ERR          one-cycle completion pulse; ERR marks a faulted (not issued) access
//   RDATA             extended load result, held until the next successful load
//   MEM_REQ/WE/ADDR/WDATA/BE   memory request, held stable until MEM_ACK
//   MEM_ACK, MEM_RDATA         memory completion and read word
module data_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RREQ,
  input  logic              CWE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              RDY,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [3:0]        MEM_BE,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_store_q, is_store_d;

  logic                is_store;
  logic                illegal;
  logic                misaligned;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   load_ext;

  // Request decode, only meaningful in StIdle
  always_comb begin
    is_store = CWE;
    illegal  = 1'b0;
    if (is_store) begin
      illegal = !(FUNCT3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = !(FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    misaligned = 1'b0;
    if (FUNCT3[1:0] == 2'b01) misaligned = ADDR[0];
    if (FUNCT3[1:0] == 2'b10) misaligned = (ADDR[1:0] != 2'b00);
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend
  always_comb begin
    rd_shift = MEM_RDATA >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = MEM_RDATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdy_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;

    unique case (state_q)
      StIdle: begin
        if (CWE || RREQ) begin
          if (illegal || misaligned) begin
            // Fault: complete next cycle without touching memory
            state_d = StDone;
            rdy_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = StWait;
            off_d      = ADDR[1:0];
            funct3_d   = FUNCT3;
            is_store_d = is_store;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {ADDR[ADDR_W-1:2], 2'b00};
            if (is_store) begin
              case (FUNCT3[1:0])
                2'b00: begin
                  mem_be_d    = 4'b0001 << ADDR[1:0];
                  mem_wdata_d = {4{WDATA[7:0]}};
                end
                2'b01: begin
                  mem_be_d    = 4'b0011 << ADDR[1:0];
                  mem_wdata_d = {2{WDATA[15:0]}};
                end
                default: begin
                  mem_be_d    = 4'b1111;
                  mem_wdata_d = WDATA;
                end
              endcase
            end else begin
              mem_be_d    = 4'b1111;
              mem_wdata_d = '0;
            end
          end
        end
      end
      StWait: begin
        // Request levels are ignored here; the access runs to completion
        if (MEM_ACK) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          rdy_d     = 1'b1;
          if (!is_store_q) rdata_d = load_ext;
        end
      end
      StDone: begin
        // Requests seen here belong to the finishing instruction
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      is_store_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
    end
  end

  assign RDY       = rdy_q;
  assign ERR       = err_q;
  assign RDATA     = rdata_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_BE    = mem_be_q;

endmodule

// File: tb/tb_data_access_unit.sv
module tb_data_access_unit;

  logic        CLK;
  logic        RST_N;
  logic        RREQ;
  logic        CWE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        RDY;
  logic [31:0] RDATA;
  logic        ERR;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  int n_cmp;
  int n_bad;
  int req_rises;
  int rdy_pulses;
  logic req_prev;

  data_access_unit #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RREQ     (RREQ),
    .CWE      (CWE),
    .FUNCT3   (FUNCT3),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .RDY      (RDY),
    .RDATA    (RDATA),
    .ERR      (ERR),
    .MEM_REQ  (MEM_REQ),
    .MEM_WE   (MEM_WE),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_BE   (MEM_BE),
    .MEM_ACK  (MEM_ACK),
    .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Free-running transaction counters; sections compare deltas
  initial begin
    req_rises  = 0;
    rdy_pulses = 0;
    req_prev   = 1'b0;
  end
  always @(posedge CLK) begin
    #1;
    if (MEM_REQ && !req_prev) req_rises = req_rises + 1;
    if (RDY) rdy_pulses = rdy_pulses + 1;
    req_prev = MEM_REQ;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // One load with ACK in the first WAIT cycle
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] mrd, input logic [31:0] exp);
    RREQ = 1'b1; FUNCT3 = f3; ADDR = a;
    tick();
    check({tag, " req"}, 32'(MEM_REQ), 32'd1);
    check({tag, " addr"}, MEM_ADDR, {a[31:2], 2'b00});
    RREQ = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = mrd;
    tick();
    check({tag, " rdy"}, 32'(RDY), 32'd1);
    check({tag, " rdata"}, RDATA, exp);
    MEM_ACK = 1'b0;
    tick();
    check({tag, " rdy off"}, 32'(RDY), 32'd0);
  endtask

  // Faulting access: RDY/ERR one cycle after request, no memory request
  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd_keep);
    CWE = st; RREQ = !st; FUNCT3 = f3; ADDR = a;
    tick();
    check({tag, " err"}, 32'(ERR), 32'd1);
    check({tag, " rdy"}, 32'(RDY), 32'd1);
    check({tag, " noreq"}, 32'(MEM_REQ), 32'd0);
    CWE = 1'b0; RREQ = 1'b0;
    tick();
    check({tag, " err off"}, 32'(ERR), 32'd0);
    check({tag, " rdata kept"}, RDATA, rd_keep);
    check({tag, " noreq2"}, 32'(MEM_REQ), 32'd0);
  endtask

  initial begin
    int r0;
    int p0;
    n_cmp = 0; n_bad = 0;
    RST_N = 1'b0; RREQ = 1'b0; CWE = 1'b0; FUNCT3 = 3'b000; ADDR = '0; WDATA = '0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    tick();
    check("rst req", 32'(MEM_REQ), 32'd0);
    check("rst rdy", 32'(RDY), 32'd0);
    check("rst err", 32'(ERR), 32'd0);
    check("rst rdata", RDATA, 32'd0);
    check("rst be", 32'(MEM_BE), 32'd0);
    check("rst addr", MEM_ADDR, 32'd0);
    RST_N = 1'b1;
    tick();

    // LW 0x100: REQ for one cycle, RDY two cycles after request
    do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    check("lw req off", 32'(MEM_REQ), 32'd0);

    do_load("lb", 3'b000, 32'h203, 32'h80FF_0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80FF_0000, 32'h00000080);
    do_load("lhu", 3'b101, 32'h202, 32'h80FF_0000, 32'h000080FF);
    do_load("lh", 3'b001, 32'h202, 32'h80FF_0000, 32'hFFFF80FF);
    do_load("lb0", 3'b000, 32'h200, 32'h1234_567F, 32'h0000007F);

    // SB with delayed ACK: outputs stable while waiting
    CWE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h11; WDATA = 32'h12345678;
    tick();
    CWE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("sb req", 32'(MEM_REQ), 32'd1);
      check("sb we", 32'(MEM_WE), 32'd1);
      check("sb be", 32'(MEM_BE), 32'b0010);
      check("sb wdata", MEM_WDATA, 32'h78787878);
      check("sb addr", MEM_ADDR, 32'h10);
      check("sb rdy", 32'(RDY), 32'd0);
      tick();
    end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    check("sb done rdy", 32'(RDY), 32'd1);
    check("sb done req", 32'(MEM_REQ), 32'd0);
    check("sb rdata kept", RDATA, 32'h0000007F);
    tick();
    check("sb rdy off", 32'(RDY), 32'd0);

    // SH at offset 2
    CWE = 1'b1; FUNCT3 = 3'b001; ADDR = 32'h46; WDATA = 32'hAAAA_BEEF;
    tick();
    CWE = 1'b0;
    check("sh be", 32'(MEM_BE), 32'b1100);
    check("sh wdata", MEM_WDATA, 32'hBEEFBEEF);
    check("sh addr", MEM_ADDR, 32'h44);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    tick();

    // Faults
    do_fault("lw mis", 1'b0, 3'b010, 32'h102, 32'h0000007F);
    do_fault("sh mis", 1'b1, 3'b001, 32'h3, 32'h0000007F);
    do_fault("sbu ill", 1'b1, 3'b100, 32'h8, 32'h0000007F);
    do_fault("ld ill", 1'b0, 3'b011, 32'h8, 32'h0000007F);

    // Back-to-back LW then SW, RREQ held through DONE
    r0 = req_rises; p0 = rdy_pulses;
    RREQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h200;
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0BAD_F00D;
    tick();
    MEM_ACK = 1'b0;
    check("b2b lw rdy", 32'(RDY), 32'd1);
    check("b2b lw rdata", RDATA, 32'h0BADF00D);
    tick();
    check("b2b no dup", 32'(MEM_REQ), 32'd0);
    RREQ = 1'b0; CWE = 1'b1; ADDR = 32'h204; WDATA = 32'hCAFEF00D;
    tick();
    CWE = 1'b0;
    check("b2b sw we", 32'(MEM_WE), 32'd1);
    check("b2b sw be", 32'(MEM_BE), 32'hF);
    check("b2b sw wdata", MEM_WDATA, 32'hCAFEF00D);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    check("b2b sw rdy", 32'(RDY), 32'd1);
    tick();
    tick();
    check("b2b reqs", 32'(req_rises - r0), 32'd2);
    check("b2b rdys", 32'(rdy_pulses - p0), 32'd2);
    check("b2b rdata kept", RDATA, 32'h0BADF00D);

    // Asynchronous reset during WAIT
    RREQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h300;
    tick();
    RREQ = 1'b0;
    check("rw req", 32'(MEM_REQ), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("rw req drop", 32'(MEM_REQ), 32'd0);
    check("rw rdy", 32'(RDY), 32'd0);
    check("rw rdata", RDATA, 32'd0);
    RST_N = 1'b1;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h5555_5555;
    tick();
    MEM_ACK = 1'b0;
    check("rw late ack rdy", 32'(RDY), 32'd0);
    check("rw late ack rdata", RDATA, 32'd0);
    tick();
    check("rw idle rdy", 32'(RDY), 32'd0);
    do_load("post rst", 3'b010, 32'h400, 32'h0123_4567, 32'h01234567);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_access_unit.md
Name: data_access_unit

Overview:
Memory-stage sequencer placed directly downstream of the instruction controller. It consumes RREQ/CWE (load/store request), the ALU-computed address and rs2 store data. It runs a req/ack transaction on the data-memory port and returns RDY, which releases HOLD. It also performs byte-lane steering for stores and alignment plus sign/zero extension for loads.

Parameters:
ADDR_W, 32, byte-address width of ADDR and MEM_ADDR
DATA_W, 32, data word width; fixed at 32 (4 byte lanes), other values unsupported

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
RREQ  input  1  load request from controller (level, held while instruction stalls)
CWE  input  1  store request from controller (level)
FUNCT3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ADDR  input  ADDR_W  effective byte address (ALU result)
WDATA  input  32  store data (rs2)
RDY  output  1  one-cycle pulse: access complete
RDATA  output  32  extended load result to writeback mux
ERR  output  1  one-cycle pulse with RDY: misaligned or illegal FUNCT3 access, no memory access made
MEM_REQ  output  1  memory request, held until acknowledged
MEM_WE  output  1  1 = write, 0 = read; valid while MEM_REQ
MEM_ADDR  output  ADDR_W  word-aligned address (ADDR with [1:0] = 00)
MEM_WDATA  output  32  lane-replicated store data
MEM_BE  output  4  byte enables
MEM_ACK  input  1  memory completion, sampled on CLK
MEM_RDATA  input  32  read word, valid in the cycle MEM_ACK = 1

Behaviour:
- Reset (async, RST_N = 0):
  - State goes to IDLE.
  - MEM_REQ, MEM_WE, RDY and ERR are 0; MEM_ADDR, MEM_WDATA and MEM_BE are 0; RDATA is 0.
  - Reset applied mid-transaction abandons the transaction immediately. No RDY is produced.
- All outputs are registered.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If CWE or RREQ is high, the access is decoded. CWE has priority if both are high; the access is then treated as a store.
  - Misaligned access: H/HU with ADDR[0] = 1, or W with ADDR[1:0] != 00. FUNCT3 values outside {000, 001, 010} for stores, or outside {000, 001, 010, 100, 101} for loads, are illegal.
  - Misaligned or illegal access: go to DONE with ERR = 1 and RDY = 1 in DONE. RDATA is unchanged and no MEM_REQ is issued.
  - Legal access: latch ADDR[1:0], FUNCT3 and the load/store flag. Drive MEM_REQ = 1, MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA from the next edge. Go to WAIT.
- WAIT:
  - MEM_REQ and all MEM_* outputs are held stable until MEM_ACK = 1 is sampled.
  - On the MEM_ACK edge: MEM_REQ drops; a load writes the extended RDATA; go to DONE.
  - RREQ/CWE dropping during WAIT is ignored; the transaction completes and RDY still pulses.
  - No timeout.
- DONE:
  - RDY = 1 for exactly this cycle; ERR is 1 only if the access was faulted.
  - Unconditionally return to IDLE.
  - RREQ/CWE in DONE belong to the finishing instruction and are ignored. A request seen in IDLE on the following cycle starts a new access, so back-to-back accesses are supported.
- Latency: request seen at edge 0 -> MEM_REQ high after edge 0.
  - MEM_ACK sampled at edge k (k >= 1) -> RDY high after edge k, for one cycle.
  - Minimum request-to-RDY is 2 cycles. Fault path: RDY is high after edge 0, 1 cycle.
- Store lanes (o = ADDR[1:0]):
  - B: MEM_BE = 0001 << o; MEM_WDATA = WDATA[7:0] replicated ×4.
  - H: MEM_BE = 0011 << o; MEM_WDATA = WDATA[15:0] replicated ×2.
  - W: MEM_BE = 1111; MEM_WDATA = WDATA.
- Loads: MEM_BE = 1111 and MEM_WDATA = 0.
  - Byte = MEM_RDATA[8o+7:8o]. Half = MEM_RDATA[8o+15:8o] (o = 0 or 2).
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- RDATA holds its value until the next successful load completes; stores and faults do not change it.

Test Plan:
- Reset, RREQ = 1, FUNCT3 = 010, ADDR = 0x100, MEM_ACK on the first WAIT cycle with MEM_RDATA = 0xDEADBEEF -> MEM_REQ high 1 cycle, MEM_ADDR = 0x100, RDY pulse 2 cycles after request, RDATA = 0xDEADBEEF.
- LB ADDR = 0x203, MEM_RDATA = 0x80FF_0000 -> RDATA = 0xFFFFFF80; LBU same -> 0x00000080; LHU ADDR = 0x202 -> 0x000080FF.
- SB ADDR = 0x11, WDATA = 0x12345678 -> MEM_BE = 0010, MEM_WDATA = 0x78787878, MEM_WE = 1, MEM_ADDR = 0x10; ACK delayed 5 cycles -> outputs stable throughout, RDY one cycle after ACK, RDATA unchanged.
- LW ADDR = 0x102 -> ERR = 1 and RDY = 1 one cycle after request, MEM_REQ never asserted; SH ADDR = 0x3 -> same.
- Back-to-back LW, SW with RREQ held through DONE -> exactly two MEM_REQ transactions, two RDY pulses, no duplicate access.
- RST_N low during WAIT -> MEM_REQ and RDY drop immediately (no clock edge needed), state IDLE; late MEM_ACK after reset is ignored.
